keypad_debounce_scheduler: RTL and testbench

Shared-debounce controller for the microwave keypad input encoder. It takes NUM_KEYS raw active-high key lines and drives a single shared debounce counter, instead of one debouncer per key. It grants that counter to one requester (key) at a time by fixed priority and reports each qualified press once, as a key code plus a one-cycle valid pulse. It sits between the raw keypad pins and the BCD/command encoder.

---
 rtl/keypad_debounce_scheduler.sv | 131 +++++++++++++
 tb/tb_keypad_debounce_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce_scheduler.sv
// Shared-debounce keypad controller: one saturating counter is granted to the
// lowest-index pressed key, and each qualified press is reported once as code + valid.
module keypad_debounce_scheduler #(
    parameter int unsigned NUM_KEYS   = 10,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CODE_W     = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [CODE_W-1:0]   code,
    output logic                valid,
    output logic                busy,
    output logic                held
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int unsigned IDX_W = $clog2(NUM_KEYS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [IDX_W-1:0]    owner, owner_d;
    logic [CODE_W-1:0]   code_d;
    logic                valid_d;

    logic [NUM_KEYS-1:0] keys_m, keys_s;
    logic [IDX_W-1:0]    low_idx;
    logic                own_key;
    logic [CNT_W-1:0]    cnt_sat;
    logic                cnt_last;

    // Two-flop synchroniser; cleared so a key held across clr is seen as a fresh press
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            keys_m <= '0;
            keys_s <= '0;
        end else begin
            keys_m <= keys;
            keys_s <= keys_m;
        end
    end

    // Fixed-priority pick: index 0 wins
    always_comb begin
        low_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys_s[i]) low_idx = IDX_W'(i);
        end
    end

    assign own_key  = keys_s[owner];
    assign cnt_sat  = (cnt == CNT_W'(DEB_CYCLES)) ? cnt : cnt + CNT_W'(1);
    assign cnt_last = (({1'b0, cnt} + (CNT_W + 1)'(1)) == (CNT_W + 1)'(DEB_CYCLES));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= '0;
            code  <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            owner <= owner_d;
            code  <= code_d;
            valid <= valid_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        owner_d = owner;
        code_d  = code;
        valid_d = 1'b0;
        case (state)
            IDLE: begin
                if (|keys_s) begin
                    owner_d = low_idx;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // Other keys are ignored while the counter is owned
                if (own_key) begin
                    cnt_d = cnt_sat;
                    if (cnt_last) begin
                        state_d = HOLD;
                        code_d  = CODE_W'(owner);
                        valid_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!own_key) begin
                    if (DEB_CYCLES == 1) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (!own_key) begin
                    cnt_d = cnt_sat;
                    if (cnt_last) state_d = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign held = (state == HOLD) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_debounce_scheduler.sv
// Directed bench for keypad_debounce_scheduler: default instance (10 keys, 4-cycle
// debounce) plus a 16-key, 1-cycle-debounce instance for the edge parameters.
module tb_keypad_debounce_scheduler;

    logic        clk = 1'b0;
    logic        clr;
    logic [9:0]  keys;
    logic [3:0]  code;
    logic        valid, busy, held;
    logic [15:0] keys1;
    logic [3:0]  code1;
    logic        valid1, busy1, held1;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;
    int vcnt1 = 0;
    int v0;

    keypad_debounce_scheduler #(.NUM_KEYS(10), .DEB_CYCLES(4), .CODE_W(4)) dut (
        .clk(clk), .clr(clr), .keys(keys), .code(code),
        .valid(valid), .busy(busy), .held(held)
    );

    keypad_debounce_scheduler #(.NUM_KEYS(16), .DEB_CYCLES(1), .CODE_W(4)) dut1 (
        .clk(clk), .clr(clr), .keys(keys1), .code(code1),
        .valid(valid1), .busy(busy1), .held(held1)
    );

    always #5 clk = ~clk;

    // Pulse counters: each valid pulse spans exactly one rising edge
    always @(posedge clk) begin
        if (valid)  vcnt  <= vcnt + 1;
        if (valid1) vcnt1 <= vcnt1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clr   = 1'b1;
        keys  = '0;
        keys1 = '0;
        #1;
        chk("rst_code",  32'(code),  0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_held",  32'(held),  0);
        chk("rst_busy1", 32'(busy1), 0);
        tick(2);
        clr = 1'b0;
        tick(3);

        // Clean press of key 5, held 20 cycles
        keys = 10'(1 << 5);
        v0 = vcnt;
        tick(3);
        chk("clean_busy_n3", 32'(busy), 1);
        chk("clean_held_n3", 32'(held), 0);
        tick(3);
        chk("clean_valid_n6", 32'(valid), 0);
        tick(1);
        chk("clean_valid_n7", 32'(valid), 1);
        chk("clean_code_n7",  32'(code),  5);
        chk("clean_held_n7",  32'(held),  1);
        tick(1);
        chk("clean_valid_n8", 32'(valid), 0);
        tick(12);
        keys = '0;
        tick(5);
        chk("clean_held_n25", 32'(held), 1);
        tick(1);
        chk("clean_held_n26", 32'(held), 0);
        chk("clean_busy_n26", 32'(busy), 0);
        chk("clean_code_keep", 32'(code), 5);
        chk("clean_pulses", 32'(vcnt - v0), 1);

        // Reset mid-debounce with key 3 held
        tick(2);
        keys = 10'(1 << 3);
        tick(4);
        chk("rstmid_busy_pre", 32'(busy), 1);
        clr = 1'b1;
        #1;
        chk("rstmid_code",  32'(code),  0);
        chk("rstmid_valid", 32'(valid), 0);
        chk("rstmid_busy",  32'(busy),  0);
        chk("rstmid_held",  32'(held),  0);
        tick(1);
        clr = 1'b0;
        v0 = vcnt;
        tick(6);
        chk("rstmid_valid_n11", 32'(valid), 0);
        tick(1);
        chk("rstmid_valid_n12", 32'(valid), 1);
        chk("rstmid_code_n12",  32'(code),  3);
        tick(1);
        keys = '0;
        tick(7);
        chk("rstmid_idle", 32'(busy), 0);
        chk("rstmid_pulses", 32'(vcnt - v0), 1);

        // Bounce on press: key 2 high 2, low 1, high 10
        tick(2);
        keys = 10'(1 << 2);
        v0 = vcnt;
        tick(2);
        keys = '0;
        tick(1);
        keys = 10'(1 << 2);
        chk("bpress_busy_n3", 32'(busy), 1);
        tick(1);
        chk("bpress_busy_n4", 32'(busy), 1);
        tick(1);
        chk("bpress_abort_n5", 32'(busy), 0);
        tick(1);
        chk("bpress_busy_n6", 32'(busy), 1);
        tick(3);
        chk("bpress_valid_n9", 32'(valid), 0);
        tick(1);
        chk("bpress_valid_n10", 32'(valid), 1);
        chk("bpress_code_n10",  32'(code),  2);
        tick(3);
        keys = '0;
        tick(6);
        chk("bpress_idle", 32'(busy), 0);
        chk("bpress_pulses", 32'(vcnt - v0), 1);

        // Bounce on release: key 7 qualified, then low 2, high 1, low
        tick(2);
        keys = 10'(1 << 7);
        v0 = vcnt;
        tick(7);
        chk("brel_valid_n7", 32'(valid), 1);
        chk("brel_code_n7",  32'(code),  7);
        tick(3);
        keys = '0;
        tick(2);
        keys = 10'(1 << 7);
        tick(1);
        keys = '0;
        tick(1);
        chk("brel_held_n14", 32'(held), 1);
        tick(4);
        chk("brel_busy_n18", 32'(busy), 1);
        chk("brel_held_n18", 32'(held), 1);
        tick(1);
        chk("brel_busy_n19", 32'(busy), 0);
        chk("brel_held_n19", 32'(held), 0);
        chk("brel_pulses", 32'(vcnt - v0), 1);

        // Priority: keys 4 and 1 together, key 0 arrives during key 1's debounce
        tick(2);
        keys = 10'h012;
        v0 = vcnt;
        tick(4);
        keys = 10'h013;
        tick(3);
        chk("prio_valid_n7", 32'(valid), 1);
        chk("prio_code_n7",  32'(code),  1);
        tick(3);
        keys = 10'h011;
        tick(6);
        chk("prio_idle_n16", 32'(busy), 0);
        tick(1);
        chk("prio_busy_n17", 32'(busy), 1);
        tick(3);
        chk("prio_valid_n20", 32'(valid), 0);
        chk("prio_code_n20",  32'(code),  1);
        tick(1);
        chk("prio_valid_n21", 32'(valid), 1);
        chk("prio_code_n21",  32'(code),  0);
        tick(1);
        keys = '0;
        tick(7);
        chk("prio_idle_end", 32'(busy), 0);
        chk("prio_pulses", 32'(vcnt - v0), 2);

        // One-cycle debounce, 16 keys, top code 15
        tick(2);
        keys1 = 16'h8000;
        v0 = vcnt1;
        tick(3);
        chk("d1_busy_n3",  32'(busy1),  1);
        chk("d1_valid_n3", 32'(valid1), 0);
        tick(1);
        chk("d1_valid_n4", 32'(valid1), 1);
        chk("d1_code_n4",  32'(code1),  15);
        chk("d1_held_n4",  32'(held1),  1);
        tick(1);
        chk("d1_valid_n5", 32'(valid1), 0);
        tick(1);
        keys1 = '0;
        tick(2);
        chk("d1_held_n8", 32'(held1), 1);
        tick(1);
        chk("d1_busy_n9", 32'(busy1), 0);
        chk("d1_held_n9", 32'(held1), 0);
        chk("d1_pulses", 32'(vcnt1 - v0), 1);
        tick(1);
        keys1 = 16'h8200;
        tick(4);
        chk("d1_prio_valid", 32'(valid1), 1);
        chk("d1_prio_code",  32'(code1),  9);
        keys1 = '0;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
